// File: rtl/prng_job_arbiter.sv
// Round-robin job arbiter in front of a shared xorshift32 generator.
// Each accepted job streams len successive iterates of its seed, tagged with the owner id.
module prng_job_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_seed,
  input  logic [8*N_REQ-1:0]  req_len,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic [ID_W-1:0]     out_id,
  output logic                out_last,
  output logic                busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     seed_q, seed_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grant;
  logic            found;
  logic [7:0]      len_sel;
  logic [31:0]     word;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] x1, x2;
    x1 = s ^ (s << 13);
    x2 = x1 ^ (x1 >> 17);
    return x2 ^ (x2 << 5);
  endfunction

  assign word = xorshift32(seed_q);

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        grant = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign len_sel = req_len[8*int'(grant) +: 8];

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    cur_id_d  = cur_id_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[grant] = 1'b1;
          seed_d   = req_seed[32*int'(grant) +: 32];
          cnt_d    = (len_sel == 8'd0) ? 9'd256 : {1'b0, len_sel};
          cur_id_d = grant;
          ptr_d    = grant;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Abort wins over a simultaneous beat: the word is not consumed.
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          seed_d = word;
          cnt_d  = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      seed_q   <= '0;
      cnt_q    <= '0;
      cur_id_q <= '0;
      ptr_q    <= ID_W'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      cur_id_q <= cur_id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign out_valid = busy;
  assign out_data  = word;
  assign out_id    = busy ? cur_id_q : '0;
  assign out_last  = busy && (cnt_q == 9'd1);

endmodule

// File: tb/tb_prng_job_arbiter.sv
// Bench for prng_job_arbiter: job-level reference model plus directed literal checks.
module tb_prng_job_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_seed;
  logic [8*N-1:0]  req_len;
  logic [N-1:0]    req_ready;
  logic            abort;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [IW-1:0]   out_id;
  logic            out_last;
  logic            busy;

  prng_job_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_seed(req_seed),
    .req_len(req_len), .req_ready(req_ready), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Job-level model: current job owner, words still owed, last word produced.
  bit          m_run;
  int          m_id, m_rem, m_ptr;
  logic [31:0] m_seed;
  int          grants[$];
  int          grant_t[$];
  int          beat_ids[$];
  bit          beat_last[$];

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] a, b;
    a = s ^ (s << 13);
    b = a ^ (a >> 17);
    return b ^ (b << 5);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int m_grant();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Check outputs against the model, take one clock edge, advance the model.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rr;
    #2;
    g = m_run ? -1 : m_grant();
    exp_rr = '0;
    if (g >= 0) exp_rr[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rr));
    chk("out_valid", 64'(out_valid), 64'(m_run));
    chk("busy", 64'(busy), 64'(m_run));
    chk("out_id", 64'(out_id), m_run ? 64'(m_id) : 64'd0);
    chk("out_last", 64'(out_last), 64'(m_run && m_rem == 1));
    chk("out_data", 64'(out_data), 64'(xs(m_seed)));
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_run = 0; m_seed = '0; m_rem = 0; m_id = 0; m_ptr = N - 1;
    end else if (!m_run) begin
      if (g >= 0) begin
        m_seed = req_seed[32*g +: 32];
        m_rem  = (req_len[8*g +: 8] == 8'd0) ? 256 : int'(req_len[8*g +: 8]);
        m_id   = g;
        m_ptr  = g;
        m_run  = 1;
        grants.push_back(g);
        grant_t.push_back(cyc);
      end
    end else if (abort) begin
      m_run = 0;
    end else if (out_ready) begin
      beat_ids.push_back(m_id);
      beat_last.push_back(m_rem == 1);
      m_seed = xs(m_seed);
      m_rem--;
      if (m_rem == 0) m_run = 0;
    end
    #1;
    if (g >= 0 && !rst) req_valid[g] = 1'b0;
  endtask

  task automatic set_job(input int i, input logic [31:0] s, input logic [7:0] l);
    req_seed[32*i +: 32] = s;
    req_len[8*i +: 8]    = l;
    req_valid[i]         = 1'b1;
  endtask

  initial begin
    int last_cnt;
    m_run = 0; m_seed = '0; m_rem = 0; m_id = 0; m_ptr = N - 1;
    rst = 1'b1; req_valid = '0; req_seed = '0; req_len = '0; abort = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);

    // Basic job
    set_job(0, 32'h1, 8'd2);
    #1;
    chk("basic req_ready", 64'(req_ready), 64'h1);
    cycle();
    chk("basic word1", 64'(out_data), 64'h00042021);
    chk("basic last1", 64'(out_last), 64'd0);
    cycle();
    chk("basic word2", 64'(out_data), 64'h04080601);
    chk("basic last2", 64'(out_last), 64'd1);
    cycle();
    chk("basic idle", 64'(busy), 64'd0);

    // Backpressure
    set_job(0, 32'h1, 8'd2);
    cycle();
    out_ready = 1'b0;
    repeat (5) begin
      chk("bp hold", 64'(out_data), 64'h00042021);
      chk("bp last", 64'(out_last), 64'd0);
      cycle();
    end
    out_ready = 1'b1;
    chk("bp resume1", 64'(out_data), 64'h00042021);
    cycle();
    chk("bp resume2", 64'(out_data), 64'h04080601);
    cycle();

    // Fairness after reset
    rst = 1'b1; cycle(); rst = 1'b0;
    grants.delete(); grant_t.delete();
    for (int i = 0; i < N; i++) set_job(i, 32'h1234 + i, 8'd1);
    repeat (10) begin
      cycle();
      req_valid = '1;
    end
    req_valid = '0;
    chk("fair count", 64'(grants.size()), 64'd5);
    if (grants.size() == 5) begin
      chk("fair g0", 64'(grants[0]), 64'd0);
      chk("fair g1", 64'(grants[1]), 64'd1);
      chk("fair g2", 64'(grants[2]), 64'd2);
      chk("fair g3", 64'(grants[3]), 64'd3);
      chk("fair g4", 64'(grants[4]), 64'd0);
      for (int i = 1; i < 5; i++) chk("fair spacing", 64'(grant_t[i] - grant_t[i-1]), 64'd2);
    end

    // len=0 means 256 words
    beat_ids.delete(); beat_last.delete();
    set_job(2, 32'hdeadbeef, 8'd0);
    cycle();
    for (int i = 0; i < 300 && busy; i++) cycle();
    chk("len0 beats", 64'(beat_ids.size()), 64'd256);
    last_cnt = 0;
    foreach (beat_ids[i]) begin
      if (beat_ids[i] != 2) chk("len0 id", 64'(beat_ids[i]), 64'd2);
      if (beat_last[i]) last_cnt++;
    end
    chk("len0 last count", 64'(last_cnt), 64'd1);
    if (beat_last.size() == 256) chk("len0 last pos", 64'(beat_last[255]), 64'd1);

    // Abort during third beat; ptr now at 2 after the len=0 job, requester 1 wins
    beat_ids.delete(); beat_last.delete(); grants.delete();
    set_job(1, 32'h55aa, 8'd10);
    cycle();
    cycle(); cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort idle", 64'(busy), 64'd0);
    chk("abort beats", 64'(beat_ids.size()), 64'd2);
    foreach (beat_last[i]) chk("abort no last", 64'(beat_last[i]), 64'd0);
    set_job(0, 32'h9, 8'd1);
    set_job(2, 32'h7, 8'd1);
    #1;
    chk("abort next grant", 64'(req_ready), 64'h4);
    cycle(); cycle();
    cycle(); cycle();

    // Reset mid-job
    set_job(3, 32'hcafe, 8'd10);
    cycle(); cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_id", 64'(out_id), 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    for (int i = 0; i < N; i++) set_job(i, 32'h100 + i, 8'd1);
    #1;
    chk("rst next grant", 64'(req_ready), 64'h1);
    req_valid = '0;
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0)
            set_job(i, ($urandom_range(7) == 0) ? 32'd0 : $urandom,
                    ($urandom_range(31) == 0) ? 8'd0 : 8'($urandom_range(12)));
        end else if ($urandom_range(19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(9) < 7);
      abort     = ($urandom_range(29) == 0);
      rst       = ($urandom_range(499) == 0);
      cycle();
    end
    rst = 1'b0; abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prng_job_arbiter.md
Name: prng_job_arbiter

Overview:
- Shares one xorshift32 random-number generator between N_REQ requesters.
- Each requester submits a job of (seed, length). The block grants jobs round-robin, runs the generator one word per accepted output beat, and tags every word with the requester id.
- Sits in the generator clock domain, in front of the async FIFO write side. out_ready is the FIFO "not full" indication.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; 2**ID_W >= N_REQ.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester job request, held until accepted
- req_seed  in  32*N_REQ  seed of requester i at [32*i+31:32*i]
- req_len  in  8*N_REQ  word count of requester i at [8*i+7:8*i]; 0 means 256
- req_ready  out  N_REQ  one-hot accept pulse, combinational
- abort  in  1  drop the current job
- out_valid  out  1  output word valid
- out_ready  in  1  downstream can take a word
- out_data  out  32  random word
- out_id  out  ID_W  id of the requester that owns the word
- out_last  out  1  final word of the job
- busy  out  1  high while a job is active

Behaviour:
- Reset: synchronous. On clk with rst=1:
  - state=IDLE, seed_reg=0, cnt=0, cur_id=0, ptr=N_REQ-1
  - all outputs 0 (out_data=xorshift(0)=0)
- Mid-job reset discards the job. No out_last is produced.
- Generator: out_data = f(seed_reg), combinational, where
  - x1 = s ^ (s<<13)
  - x2 = x1 ^ (x1>>17)
  - x3 = x2 ^ (x2<<5)
  - All shifts are logical with 32-bit truncation.
- Seed 0 is not substituted; it yields all-zero words.
- States: IDLE, RUN.
- IDLE:
  - grant = first i with req_valid[i] set, searching ptr+1, ptr+2, ... modulo N_REQ.
  - req_ready[grant]=1 for this cycle only; all other req_ready bits are 0.
  - On the accepting edge: seed_reg<=req_seed[grant], cnt<=(len==0?256:len) as 9 bits, cur_id<=grant, ptr<=grant, state<=RUN.
  - If no req_valid bit is set, stay in IDLE.
- RUN:
  - out_valid=1, out_id=cur_id, busy=1, out_last=(cnt==1).
  - A beat fires when out_valid && out_ready. On a beat: seed_reg<=out_data, cnt<=cnt-1.
  - If the beat has out_last=1, state<=IDLE.
  - out_ready=0: hold everything. out_data must stay stable while out_valid=1 and the beat has not fired.
- abort in RUN: state<=IDLE on that edge and no beat counts, regardless of out_ready. abort in IDLE is ignored.
- Latency:
  - Accept in cycle T gives first out_valid in T+1.
  - At least one IDLE cycle separates consecutive jobs, so req_ready is never high in RUN.
- req_ready is 0 outside IDLE. A requester deasserting req_valid before acceptance withdraws its request and must not be granted.
- Round-robin guarantee: with all requesters continuously valid, the grants after reset go 0,1,...,N_REQ-1,0,...
- Output words of a job are exactly the successive xorshift iterates of the seed; the seed itself is never output.
- busy = (state==RUN). out_valid, out_id and out_last are 0 in IDLE.

Test Plan:
- Basic job:
  - Stimulus: reset, then req_valid=0001, seed0=32'h00000001, len0=2, out_ready=1.
  - Required: req_ready=0001 for 1 cycle; next cycle out_data=32'h00042021, id 0, last 0; then 32'h04080601, last 1; then IDLE.
- Backpressure:
  - Stimulus: same job, out_ready held low for 5 cycles after out_valid rises.
  - Required: out_data stays 32'h00042021 and cnt is unchanged for those 5 cycles; the sequence resumes identically.
- Fairness:
  - Stimulus: all 4 req_valid held high, each len=1.
  - Required: grant order 0,1,2,3,0; each job is 1 beat followed by 1 IDLE cycle.
- len=0:
  - Stimulus: requester 2 with len=0.
  - Required: exactly 256 beats with out_id=2; out_last is set only on beat 256.
- abort:
  - Stimulus: abort asserted during beat 3 of a len=10 job.
  - Required: no beat counted that cycle; IDLE next cycle; out_last never seen; the next grant follows ptr.
- Reset mid-job:
  - Stimulus: rst=1 for 1 cycle in RUN.
  - Required: all outputs 0 the next cycle; ptr=3 so requester 0 wins the next arbitration.
